// File: rtl/alu_mul_sequencer_if.sv
// Request/response handshake between the instruction control unit and alu_mul_sequencer.
interface alu_mul_sequencer_if;
    logic        start;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        ready;
    logic        done;
    logic [63:0] product;
    logic        overflow;

    modport master (
        output start, a_in, b_in,
        input  ready, done, product, overflow
    );

    modport slave (
        input  start, a_in, b_in,
        output ready, done, product, overflow
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 64-bit unsigned multiplier controller driving an external combinational ALU.
// Optional sticky overflow detection is built when ALU_MUL_OVF_EN is defined.
module alu_mul_sequencer (
    input  logic                      clock,
    input  logic                      reset_n,
    alu_mul_sequencer_if.slave        bus,
    output logic [63:0]               alu_a,
    output logic [63:0]               alu_b,
    output logic [4:0]                alu_fs,
    input  logic [63:0]               alu_f,
    input  logic [3:0]                alu_status
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAdd   = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [4:0] FsAdd   = 5'b01000;
    localparam logic [4:0] FsShl   = 5'b10000;
    localparam logic [4:0] FsZero  = 5'b00000;

    logic [1:0]  state_q, state_d;
    logic [63:0] mcand_q, mcand_d;
    logic [63:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] product_q, product_d;
    logic [63:0] m1;
    logic        accept;
    logic        enter_done;

    assign m1     = mplier_q >> 1;
    assign accept = (state_q == StIdle) && bus.start;

    // Product is loaded on the edge entering DONE so it is valid while done is high.
    assign enter_done = (accept && (bus.b_in == 64'd0)) ||
                        ((state_q == StShift) && (m1 == 64'd0));

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mcand_d  = bus.a_in;
                    mplier_d = bus.b_in;
                    acc_d    = 64'd0;
                    if (bus.b_in == 64'd0) begin
                        state_d = StDone;
                    end else if (bus.b_in[0]) begin
                        state_d = StAdd;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StAdd: begin
                acc_d   = alu_f;
                state_d = StShift;
            end
            StShift: begin
                mcand_d  = alu_f;
                mplier_d = m1;
                if (m1 == 64'd0) begin
                    state_d = StDone;
                end else if (m1[0]) begin
                    state_d = StAdd;
                end else begin
                    state_d = StShift;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (enter_done) begin
            product_d = (state_q == StIdle) ? 64'd0 : acc_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            mcand_q   <= 64'd0;
            mplier_q  <= 64'd0;
            acc_q     <= 64'd0;
            product_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

`ifdef ALU_MUL_OVF_EN
    logic ovf_q, ovf_d;
    logic overflow_q, overflow_d;
    logic unused_status;

    assign unused_status = ^{alu_status[3], alu_status[1:0]};

    // A carry out of the accumulator or a bit shifted out of mcand that would still be
    // added later both mean the true product no longer fits in 64 bits.
    always_comb begin
        ovf_d      = ovf_q;
        overflow_d = overflow_q;
        if (accept) begin
            ovf_d = 1'b0;
        end
        if ((state_q == StAdd) && alu_status[2]) begin
            ovf_d = 1'b1;
        end
        if ((state_q == StShift) && mcand_q[63] && (m1 != 64'd0)) begin
            ovf_d = 1'b1;
        end
        if (enter_done) begin
            overflow_d = (state_q == StIdle) ? 1'b0 : ovf_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`else
    logic unused_status;

    assign unused_status = ^alu_status;
    assign bus.overflow  = 1'b0;
`endif

    always_comb begin
        alu_a  = 64'd0;
        alu_b  = 64'd0;
        alu_fs = FsZero;
        unique case (state_q)
            StAdd: begin
                alu_a  = acc_q;
                alu_b  = mcand_q;
                alu_fs = FsAdd;
            end
            StShift: begin
                alu_a  = mcand_q;
                alu_b  = 64'd1;
                alu_fs = FsShl;
            end
            default: begin
                alu_a  = 64'd0;
                alu_b  = 64'd0;
                alu_fs = FsZero;
            end
        endcase
    end

    assign bus.ready   = (state_q == StIdle);
    assign bus.done    = (state_q == StDone);
    assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed self-checking bench for alu_mul_sequencer with a behavioural ALU model.
module tb_alu_mul_sequencer;

    logic        clock;
    logic        reset_n;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [4:0]  alu_fs;
    logic [63:0] alu_f;
    logic [3:0]  alu_status;

    int checks = 0;
    int errors = 0;

    alu_mul_sequencer_if bus ();

    alu_mul_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fs     (alu_fs),
        .alu_f      (alu_f),
        .alu_status (alu_status)
    );

    // Behavioural ALU: FS[4:2] op, FS[1] inverts A, FS[0] inverts B and is carry-in.
    logic [63:0] ai, bi;
    logic        cout, vflag;
    always_comb begin
        ai    = alu_fs[1] ? ~alu_a : alu_a;
        bi    = alu_fs[0] ? ~alu_b : alu_b;
        cout  = 1'b0;
        vflag = 1'b0;
        alu_f = ai;
        case (alu_fs[4:2])
            3'b010: begin
                {cout, alu_f} = {1'b0, ai} + {1'b0, bi} + {64'd0, alu_fs[0]};
                vflag = (ai[63] == bi[63]) && (alu_f[63] != ai[63]);
            end
            3'b100: alu_f = ai << bi[5:0];
            default: alu_f = ai;
        endcase
        alu_status = {vflag, cout, (alu_f == 64'd0), alu_f[63]};
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; lat=-1 if it never comes.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input bit hold,
                         output int lat, output logic [24:0] seq, output int nfs);
        @(negedge clock);
        chk("ready_before_start", {63'd0, bus.ready}, 64'd1);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        lat = -1;
        seq = 25'd0;
        nfs = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clock);
            if (!hold) bus.start = 1'b0;
            if (hold && n == 2) begin
                bus.a_in = 64'd2;
                bus.b_in = 64'd2;
            end
            if (alu_fs != 5'd0) begin
                seq = {seq[19:0], alu_fs};
                nfs++;
            end
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    int          lat;
    int          lat2;
    int          nfs;
    logic [24:0] seq;
    bit          saw_done;

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.a_in  = 64'd0;
        bus.b_in  = 64'd0;
        repeat (2) @(negedge clock);
        chk("rst_ready", {63'd0, bus.ready}, 64'd1);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_product", bus.product, 64'd0);
        chk("rst_overflow", {63'd0, bus.overflow}, 64'd0);
        chk("rst_alu_fs", {59'd0, alu_fs}, 64'd0);
        reset_n = 1'b1;

        // 3*5
        do_op(64'd3, 64'd5, 1'b0, lat, seq, nfs);
        chk("3x5_latency", 64'(lat), 64'd6);
        chk("3x5_product", bus.product, 64'd15);
        chk("3x5_overflow", {63'd0, bus.overflow}, 64'd0);
        chk("3x5_fs_count", 64'(nfs), 64'd5);
        chk("3x5_fs_seq", {39'd0, seq}, {39'd0, 25'b01000_10000_10000_01000_10000});
        @(negedge clock);
        chk("3x5_done_one_cycle", {63'd0, bus.done}, 64'd0);
        chk("3x5_ready_after", {63'd0, bus.ready}, 64'd1);
        chk("3x5_product_held", bus.product, 64'd15);

        // Zero multiplier
        do_op(64'hDEAD, 64'd0, 1'b0, lat, seq, nfs);
        chk("zero_latency", 64'(lat), 64'd1);
        chk("zero_product", bus.product, 64'd0);
        chk("zero_fs_count", 64'(nfs), 64'd0);

        // Worst case
        do_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, seq, nfs);
        chk("ones_latency", 64'(lat), 64'd129);
        chk("ones_product", bus.product, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ones_overflow", {63'd0, bus.overflow}, 64'd0);

        // 2^63 * 2 wraps to zero
        do_op(64'h8000_0000_0000_0000, 64'd2, 1'b0, lat, seq, nfs);
        chk("big_latency", 64'(lat), 64'd4);
        chk("big_product", bus.product, 64'd0);
`ifdef ALU_MUL_OVF_EN
        chk("big_overflow", {63'd0, bus.overflow}, 64'd1);
`else
        chk("big_overflow", {63'd0, bus.overflow}, 64'd0);
`endif
        do_op(64'd2, 64'd3, 1'b0, lat, seq, nfs);
        chk("2x3_latency", 64'(lat), 64'd5);
        chk("2x3_product", bus.product, 64'd6);
        chk("2x3_overflow", {63'd0, bus.overflow}, 64'd0);

        // start held high, operands changed mid-flight
        do_op(64'd7, 64'd9, 1'b1, lat, seq, nfs);
        chk("hold_latency", 64'(lat), 64'd7);
        chk("hold_product", bus.product, 64'd63);
        @(negedge clock);
        chk("hold_done_low", {63'd0, bus.done}, 64'd0);
        chk("hold_ready_idle", {63'd0, bus.ready}, 64'd1);
        @(negedge clock);
        chk("hold_reaccept", {63'd0, bus.ready}, 64'd0);
        bus.start = 1'b0;
        lat2 = -1;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clock);
            if (bus.done) begin
                lat2 = n;
                break;
            end
        end
        chk("hold2_latency", 64'(lat2), 64'd4);
        chk("hold2_product", bus.product, 64'd4);

        // Asynchronous reset mid-operation
        @(negedge clock);
        bus.start = 1'b1;
        bus.a_in  = 64'd100;
        bus.b_in  = 64'd3;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ready", {63'd0, bus.ready}, 64'd1);
        chk("arst_done", {63'd0, bus.done}, 64'd0);
        chk("arst_product", bus.product, 64'd0);
        chk("arst_overflow", {63'd0, bus.overflow}, 64'd0);
        chk("arst_alu_fs", {59'd0, alu_fs}, 64'd0);
        repeat (2) @(negedge clock);
        reset_n  = 1'b1;
        saw_done = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (bus.done) saw_done = 1'b1;
        end
        chk("arst_no_done", {63'd0, saw_done}, 64'd0);
        do_op(64'd4, 64'd4, 1'b0, lat, seq, nfs);
        chk("4x4_latency", 64'(lat), 64'd5);
        chk("4x4_product", bus.product, 64'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle 64-bit unsigned multiplier controller that owns the datapath ALU and sequences it through shift-and-add iterations. It accepts an operand pair over a start/ready handshake and drives the ALU's A, B and FS inputs each cycle. It collects the ALU result F and status, and returns the low 64 bits of the product with a one-cycle done pulse. It sits between the instruction control unit and the ALU. The ALU itself is unchanged and stays combinational.

## Interface
- No parameters. Data width is fixed at 64; the ALU FS encoding is fixed at 5 bits.
- clock  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  reset, asynchronous and active-low
- start  in  1  request; accepted only when ready=1
- a_in  in  64  multiplicand, sampled on accept
- b_in  in  64  multiplier, sampled on accept
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse; product is valid from this cycle on
- product  out  64  low 64 bits of a_in*b_in; registered; held until the next accept
- overflow  out  1  product exceeded 64 bits (see Configuration)
- alu_a  out  64  ALU A operand
- alu_b  out  64  ALU B operand
- alu_fs  out  5  ALU function select: FS[4:2] is the operation, FS[1] inverts A, FS[0] inverts B and is the carry-in
- alu_f  in  64  ALU result
- alu_status  in  4  ALU status {V,C,Z,N}

## Operation
- Internal registers:
  - mcand (64 bits)
  - mplier (64 bits)
  - acc (64 bits)
  - state (IDLE, ADD, SHIFT, DONE)
- IDLE: ready=1. On start=1:
  - Load mcand←a_in, mplier←b_in, acc←0.
  - Next state is DONE if b_in==0, else ADD if b_in[0]=1, else SHIFT.
- ADD:
  - Drive alu_a=acc, alu_b=mcand, alu_fs=5'b01000 (add, no inversion).
  - Capture acc←alu_f.
  - Next state is SHIFT.
- SHIFT:
  - Drive alu_a=mcand, alu_b=64'd1, alu_fs=5'b10000 (shift left by B[5:0]).
  - Capture mcand←alu_f.
  - Shift mplier right by 1 locally, not through the ALU.
  - Let m1 = mplier>>1. Next state is DONE if m1==0, else ADD if m1[0]=1, else SHIFT.
- DONE:
  - product←acc; done=1 in this cycle only.
  - Next state is IDLE.
- In IDLE and DONE, drive alu_a=0, alu_b=0, alu_fs=5'b00000.
- alu_a, alu_b and alu_fs are combinational from state and registers.
- Arithmetic: unsigned, modulo 2^64. Bits beyond 63 are discarded.
- start is ignored in ADD, SHIFT and DONE. There is no queuing.
- Reset at any time forces the following immediately; the in-flight operation is lost and done is not asserted:
  - state=IDLE
  - mcand, mplier, acc, product = 0
  - overflow=0, done=0
  - ready=1

## Timing
- Accept at edge T. The DONE cycle is T+L, where L = popcount(b_in) + (index of highest set bit of b_in + 1) + 1.
  - b_in=0: L=1.
  - b_in=1: L=3.
  - b_in=all ones: L=129 (worst case).
- ready falls in the cycle after accept and rises in the cycle after DONE.
- Minimum accept-to-accept spacing is L+1 cycles.
- product and overflow update in the same cycle that done=1, and hold until the next accepted start.
- ALU result paths are combinational within one cycle. The ALU timing budget must close at the clock.

## Configuration
- ALU_MUL_OVF_EN defined: overflow is a sticky flag, cleared on accept. It is set in either case:
  - In ADD when alu_status[2] (C)=1.
  - In SHIFT when mcand[63]=1 and m1!=0.
- The flag is copied to the overflow output in the DONE cycle.
- ALU_MUL_OVF_EN undefined: overflow is tied to 0 and the sticky register is not built. product behaviour is identical in both builds.

## Test plan
- Reset, then a_in=3, b_in=5, start: done 6 cycles after accept; product=15; overflow=0; alu_fs sequence is 01000, 10000, 10000, 01000, 10000.
- a_in=0xDEAD, b_in=0, start: done 1 cycle after accept; product=0; no ADD or SHIFT cycles.
- a_in=1, b_in=all ones: done 129 cycles after accept; product=0xFFFF_FFFF_FFFF_FFFF; overflow=0.
- With ALU_MUL_OVF_EN: a_in=2^63, b_in=2: product=0, overflow=1. The next operation, 2*3, gives product=6, overflow=0.
- start held high during a 7*9 operation, with a_in and b_in changed mid-flight: the result is still 63 and only one done pulse occurs. A new accept happens in the cycle after DONE.
- reset_n pulsed low mid-operation: outputs go to their reset values immediately; no done pulse; ready=1. A subsequent 4*4 gives product=16.
